// File: rtl/mem_arbiter_if.sv
// Interface bundling the three requester handshakes, the shared read-data
// return and the single-port memory macro connection of mem_arbiter.
// slave  : arbiter side (consumes requests and memory read data).
// master : requester/memory side (drives requests and memory read data).
interface mem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              ldr_req;
   logic              ldr_we;
   logic [ADDR_W-1:0] ldr_addr;
   logic [DATA_W-1:0] ldr_wdata;
   logic              ldr_gnt;
   logic              ldr_done;

   logic              dat_req;
   logic              dat_we;
   logic [ADDR_W-1:0] dat_addr;
   logic [DATA_W-1:0] dat_wdata;
   logic              dat_gnt;
   logic              dat_done;

   logic              fet_req;
   logic [ADDR_W-1:0] fet_addr;
   logic              fet_gnt;
   logic              fet_done;

   logic [DATA_W-1:0] rdata;
   logic              busy;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
      output ldr_gnt, ldr_done,
      input  dat_req, dat_we, dat_addr, dat_wdata,
      output dat_gnt, dat_done,
      input  fet_req, fet_addr,
      output fet_gnt, fet_done,
      output rdata, busy,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output ldr_req, ldr_we, ldr_addr, ldr_wdata,
      input  ldr_gnt, ldr_done,
      output dat_req, dat_we, dat_addr, dat_wdata,
      input  dat_gnt, dat_done,
      output fet_req, fet_addr,
      input  fet_gnt, fet_done,
      input  rdata, busy,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: loader, core data port and instruction fetch
// share one synchronous-read memory, one access in flight at a time.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate dat/fet priority with a
// last-served pointer (loader stays absolute). Default is fixed ldr > dat > fet.
//
// state | meaning
// IDLE  | no access in flight, arbitrate incoming requests
// ISSUE | winner granted, access presented to memory
// RESP  | memory data returned, done pulsed, arbitrate again
module mem_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   typedef enum logic [1:0] {SRC_NONE, SRC_LDR, SRC_DAT, SRC_FET} src_t;

   state_t            state, state_nxt;
   src_t              src_q, win;
   logic              win_we, we_q;
   logic [ADDR_W-1:0] win_addr, addr_q;
   logic [DATA_W-1:0] win_wdata, wdata_q;
   logic              take;
   logic              dat_first;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic last_fet;

   // Remember which core port won last; reset value lets dat go first.
   always_ff @(posedge clk) begin
      if (rst)
         last_fet <= 1'b1;
      else if (take && win == SRC_DAT)
         last_fet <= 1'b0;
      else if (take && win == SRC_FET)
         last_fet <= 1'b1;
   end

   assign dat_first = last_fet;
`else
   assign dat_first = 1'b1;
`endif

   // Pick the winning requester and its access attributes.
   always_comb begin
      win       = SRC_NONE;
      win_we    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      if (bus.ldr_req) begin
         win       = SRC_LDR;
         win_we    = bus.ldr_we;
         win_addr  = bus.ldr_addr;
         win_wdata = bus.ldr_wdata;
      end else if (bus.dat_req && (dat_first || !bus.fet_req)) begin
         win       = SRC_DAT;
         win_we    = bus.dat_we;
         win_addr  = bus.dat_addr;
         win_wdata = bus.dat_wdata;
      end else if (bus.fet_req) begin
         win       = SRC_FET;
         win_addr  = bus.fet_addr;
      end
   end

   assign take = (state == IDLE || state == RESP) && (win != SRC_NONE);

   // State register and latch of the accepted access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         src_q   <= SRC_NONE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            src_q   <= win;
            we_q    <= win_we;
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
         end
      end
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_nxt     = state;
      bus.ldr_gnt   = 1'b0;
      bus.dat_gnt   = 1'b0;
      bus.fet_gnt   = 1'b0;
      bus.ldr_done  = 1'b0;
      bus.dat_done  = 1'b0;
      bus.fet_done  = 1'b0;
      bus.rdata     = '0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (take) state_nxt = ISSUE;
         end
         ISSUE: begin
            state_nxt     = RESP;
            bus.ldr_gnt   = (src_q == SRC_LDR);
            bus.dat_gnt   = (src_q == SRC_DAT);
            bus.fet_gnt   = (src_q == SRC_FET);
            bus.mem_en    = 1'b1;
            bus.mem_we    = we_q;
            bus.mem_addr  = addr_q;
            bus.mem_wdata = wdata_q;
         end
         RESP: begin
            state_nxt    = take ? ISSUE : IDLE;
            bus.ldr_done = (src_q == SRC_LDR);
            bus.dat_done = (src_q == SRC_DAT);
            bus.fet_done = (src_q == SRC_FET);
            bus.rdata    = bus.mem_rdata;
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule
